sdx_pad_mgr: RTL
================

Name: sdx_pad_mgr

Overview:
Sequencing controller for the single SDX pad, which is shared between the I2C slave open-drain SDA path and the OTP serial-output path, and also has a released (Hi-Z) mode.
- Filters the incoming pad level before it reaches the I2C core.
- Switches pad ownership only when the I2C bus is idle.
- Inserts a released turnaround window before every ownership change.
- Sits between the pad cell and the I2C/OTP cores.

Parameters:
FILT_LEN, 3, consecutive clocks a new synchronized input level must persist before the filtered level changes (1..15).
IDLE_CYC, 16, consecutive idle clocks required before I2C mode may be left (1..255).
TURN_CYC, 4, clocks the pad is released between modes (1..15).

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
sdx_input  input  1  raw level from SDX pad.
sdx_output  output  1  data to SDX pad.
sdx_output_en_n  output  1  SDX pad output enable, active low.
i2c_sda_o  input  1  I2C core SDA drive (0 = pull low, 1 = release).
i2c_sda_i  output  1  filtered SDA level to I2C core.
otp_dout  input  1  OTP serial data to drive on pad.
otp_oe  input  1  OTP drive enable, active high.
mode_req  input  2  requested mode: 00 I2C, 01 OTP, 10 HIZ, 11 treated as HIZ.
mode_req_vld  input  1  request strobe.
mode_busy  output  1  switch in progress; requests ignored.
cur_mode  output  2  active mode encoding; HIZ is reported as 10.
mode_ack  output  1  one-cycle pulse when the requested mode becomes active.

Behaviour:
Input path:
- Two-flop synchronizer on sdx_input, giving s; both flops reset to 1.
- Filtered level f resets to 1.
- A counter increments while s != f and clears when s == f.
- When the counter reaches FILT_LEN, f takes s and the counter clears.
- i2c_sda_i = f in I2C mode; in all other states it is 1, so the I2C core sees an idle bus.

Idle detection:
- idle_cnt increments while f == 1 and i2c_sda_o == 1; it saturates at IDLE_CYC and clears otherwise.
- bus_idle = (idle_cnt == IDLE_CYC).

FSM states: S_I2C, S_WAIT_IDLE, S_TURN, S_OTP, S_HIZ. Reset state is S_I2C.
- Request accepted on a clock edge where mode_req_vld && !mode_busy. The target is latched at that edge.
- Target equals the current mode: stay in the state; mode_ack = 1 next cycle; mode_busy never asserts.
- From S_I2C: go to S_WAIT_IDLE. Go to S_TURN on the first edge with bus_idle = 1 (the same edge as acceptance if bus_idle is already 1, i.e. skip S_WAIT_IDLE).
- From S_OTP or S_HIZ: go directly to S_TURN.
- S_TURN lasts exactly TURN_CYC cycles, then moves to the target state.
- On entry to the target: mode_ack = 1 for one cycle and cur_mode updates on the same edge.
- mode_busy = 1 in S_WAIT_IDLE and S_TURN only. It is 0 in the ack cycle, so a new request is accepted then.
- Requests while mode_busy = 1 are dropped; there is no queueing.

Pad drive (registered, decoded from current state; the new mode drives one cycle after entry):
- S_I2C: sdx_output = 0; sdx_output_en_n = i2c_sda_o (one-cycle latency).
- S_OTP: sdx_output = otp_dout; sdx_output_en_n = ~otp_oe.
- S_HIZ, S_WAIT_IDLE, S_TURN: sdx_output = 0; sdx_output_en_n = 1.
- S_WAIT_IDLE continues I2C drive so an ongoing transfer completes. Correction to the line above: in S_WAIT_IDLE, sdx_output_en_n = i2c_sda_o.

Reset values: sdx_output = 0, sdx_output_en_n = 1, i2c_sda_i = 1, mode_busy = 0, mode_ack = 0, cur_mode = 00, all counters 0.
- Reset asserted mid-switch aborts the switch immediately: pad released, return to S_I2C, no mode_ack.

Test Plan:
- Reset, then sdx_input = 1, i2c_sda_o toggles 1→0→1 -> sdx_output_en_n follows with 1-cycle latency; sdx_output stays 0; i2c_sda_i = 1; cur_mode = 00.
- FILT_LEN = 3: sdx_input low pulse of 2 clocks (after sync) -> i2c_sda_i stays 1. Low pulse of 3 clocks -> i2c_sda_i falls 3 clocks after s falls.
- I2C→OTP request with sda low for 10 cycles, then high -> mode_busy = 1; S_TURN entered IDLE_CYC = 16 clocks after sda rises; pad released 4 cycles; mode_ack pulse; cur_mode = 01; pad drives otp_dout when otp_oe = 1.
- HIZ→OTP request with TURN_CYC = 4, accepted at edge 0 -> mode_busy high cycles 1–4, mode_ack at cycle 5, cur_mode = 01. A second request during cycles 1–4 is ignored.
- Request equal to cur_mode (00) -> mode_ack next cycle; mode_busy stays 0; pad unchanged. mode_req = 11 -> ends in HIZ with cur_mode = 10.
- Assert rst during S_TURN -> same cycle: sdx_output_en_n = 1, cur_mode = 00, mode_busy = 0; no mode_ack after release.

Source files
------------

// File: rtl/sdx_pad_mgr.sv
// rtl/sdx_pad_mgr.sv - SDX pad ownership sequencer shared by the I2C slave and OTP paths
//
// Ports:
//   clk, rst          system clock (rising edge), asynchronous active-high reset
//   sdx_input         raw level from the pad cell
//   sdx_output        data to the pad cell
//   sdx_output_en_n   pad output enable, active low
//   i2c_sda_o         I2C core SDA drive (0 = pull low, 1 = release)
//   i2c_sda_i         filtered SDA level to the I2C core
//   otp_dout, otp_oe  OTP serial data and its drive enable
//   mode_req          requested mode: 00 I2C, 01 OTP, 10/11 HIZ
//   mode_req_vld      request strobe
//   mode_busy         switch in progress, requests are dropped
//   cur_mode          active mode encoding (HIZ reported as 10)
//   mode_ack          one-cycle pulse when the requested mode becomes active
module sdx_pad_mgr #(
  parameter int FILT_LEN = 3,
  parameter int IDLE_CYC = 16,
  parameter int TURN_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdx_input,
  output logic       sdx_output,
  output logic       sdx_output_en_n,
  input  logic       i2c_sda_o,
  output logic       i2c_sda_i,
  input  logic       otp_dout,
  input  logic       otp_oe,
  input  logic [1:0] mode_req,
  input  logic       mode_req_vld,
  output logic       mode_busy,
  output logic [1:0] cur_mode,
  output logic       mode_ack
);

  localparam logic [1:0] MODE_I2C = 2'b00;
  localparam logic [1:0] MODE_OTP = 2'b01;
  localparam logic [1:0] MODE_HIZ = 2'b10;

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
  localparam logic [7:0] IDLE_MAX = 8'(IDLE_CYC);
  localparam logic [3:0] TURN_MAX = 4'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_I2C,
    S_WAIT_IDLE,
    S_TURN,
    S_OTP,
    S_HIZ
  } state_t;

  state_t     state, state_next;
  logic [1:0] sync;
  logic       s;
  logic       f;
  logic [3:0] filt_cnt;
  logic [7:0] idle_cnt;
  logic       bus_idle;
  logic [3:0] turn_cnt, turn_cnt_next;
  logic [1:0] target, target_next;
  logic [1:0] cur_mode_next;
  logic       ack_next;
  logic [1:0] req_code;
  logic       accept;

  assign s        = sync[1];
  assign bus_idle = (idle_cnt == IDLE_MAX);
  assign req_code = (mode_req == MODE_I2C) ? MODE_I2C :
                    (mode_req == MODE_OTP) ? MODE_OTP : MODE_HIZ;
  assign mode_busy = (state == S_WAIT_IDLE) || (state == S_TURN);
  assign accept    = mode_req_vld && !mode_busy;

  // The I2C core keeps seeing the pad while a transfer is being drained in
  // S_WAIT_IDLE; everywhere else it sees a released (idle) bus.
  assign i2c_sda_i = ((state == S_I2C) || (state == S_WAIT_IDLE)) ? f : 1'b1;

  // Synchronizer and glitch filter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b11;
      f        <= 1'b1;
      filt_cnt <= 4'd0;
    end else begin
      sync <= {sync[0], sdx_input};
      if (s == f) begin
        filt_cnt <= 4'd0;
      end else if (filt_cnt == FILT_MAX) begin
        f        <= s;
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  // Bus idle: both the pad and our own drive released for IDLE_CYC clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 8'd0;
    end else if (f && i2c_sda_o) begin
      if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + 8'd1;
    end else begin
      idle_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_I2C;
      turn_cnt <= 4'd0;
      target   <= MODE_I2C;
      cur_mode <= MODE_I2C;
      mode_ack <= 1'b0;
    end else begin
      state    <= state_next;
      turn_cnt <= turn_cnt_next;
      target   <= target_next;
      cur_mode <= cur_mode_next;
      mode_ack <= ack_next;
    end
  end

  always_comb begin
    state_next    = state;
    turn_cnt_next = turn_cnt;
    target_next   = target;
    cur_mode_next = cur_mode;
    ack_next      = 1'b0;
    case (state)
      S_I2C, S_OTP, S_HIZ: begin
        if (accept) begin
          target_next = req_code;
          if (req_code == cur_mode) begin
            ack_next = 1'b1;
          end else begin
            turn_cnt_next = 4'd0;
            // Leaving I2C must wait for an idle bus unless it already is.
            if ((state != S_I2C) || bus_idle) state_next = S_TURN;
            else                              state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (bus_idle) begin
          state_next    = S_TURN;
          turn_cnt_next = 4'd0;
        end
      end
      S_TURN: begin
        if (turn_cnt == TURN_MAX) begin
          ack_next      = 1'b1;
          cur_mode_next = target;
          case (target)
            MODE_I2C: state_next = S_I2C;
            MODE_OTP: state_next = S_OTP;
            default:  state_next = S_HIZ;
          endcase
        end else begin
          turn_cnt_next = turn_cnt + 4'd1;
        end
      end
      default: state_next = S_I2C;
    endcase
  end

  // Registered pad drive decoded from the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdx_output      <= 1'b0;
      sdx_output_en_n <= 1'b1;
    end else begin
      case (state)
        S_I2C, S_WAIT_IDLE: begin
          sdx_output      <= 1'b0;
          sdx_output_en_n <= i2c_sda_o;
        end
        S_OTP: begin
          sdx_output      <= otp_dout;
          sdx_output_en_n <= ~otp_oe;
        end
        default: begin
          sdx_output      <= 1'b0;
          sdx_output_en_n <= 1'b1;
        end
      endcase
    end
  end

endmodule
